// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two 16-bit async SRAM accesses, low half first.
// Latency 2*ACCESS_CYCLES+1 cycles with ready low (pipeline freeze) until the DONE cycle.
module sram_controller #(
   parameter int BASE_ADDR     = 1024,
   parameter int SRAM_ADDR_W   = 18,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdEn,
   input  logic                   wrEn,
   input  logic [31:0]            address,
   input  logic [31:0]            writeData,
   output logic [31:0]            readData,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sramAddr,
   inout  wire  [15:0]            sramDq,
   output logic                   sramWeN,
   output logic                   sramOeN
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   localparam logic [31:0] BASE32    = BASE_ADDR;
   localparam logic [3:0]  LAST_CNT  = 4'(ACCESS_CYCLES - 1);

   state_t                 state;
   state_t                 nextState;
   logic [3:0]             cnt;
   logic                   lastCycle;
   logic                   opWrite;
   logic [SRAM_ADDR_W-2:0] wordIdx;
   logic [SRAM_ADDR_W-2:0] inIdx;
   logic [31:0]            wdata;
   logic                   nextWrite;
   logic [SRAM_ADDR_W-2:0] nextIdx;
   logic                   dqDrive;
   logic [15:0]            dqOut;

   // Word index wraps modulo the SRAM word count; addresses below BASE_ADDR are not flagged.
   assign inIdx     = (SRAM_ADDR_W-1)'((address - BASE32) >> 2);
   assign lastCycle = (cnt == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= nextState;
         if (nextState == state && (state == LO || state == HI))
            cnt <= cnt + 4'd1;
         else
            cnt <= '0;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (rdEn | wrEn) nextState = LO;
         LO:      if (lastCycle) nextState = HI;
         HI:      if (lastCycle) nextState = DONE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      ready     = (state == DONE) || (state == IDLE && !rdEn && !wrEn);
      dqDrive   = opWrite && (state == LO || state == HI);
      dqOut     = (state == HI) ? wdata[31:16] : wdata[15:0];
      // Pins are registered, so they are set up from the operation the next cycle will carry.
      nextWrite = (state == IDLE) ? wrEn  : opWrite;
      nextIdx   = (state == IDLE) ? inIdx : wordIdx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opWrite <= 1'b0;
         wordIdx <= '0;
         wdata   <= '0;
      end else if (state == IDLE && (rdEn || wrEn)) begin
         opWrite <= wrEn;
         wordIdx <= inIdx;
         wdata   <= writeData;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         readData <= '0;
         sramAddr <= '0;
         sramWeN  <= 1'b1;
         sramOeN  <= 1'b1;
      end else begin
         sramWeN <= 1'b1;
         sramOeN <= 1'b1;
         if (nextState == LO || nextState == HI) begin
            sramAddr <= {nextIdx, nextState == HI};
            sramWeN  <= ~nextWrite;
            sramOeN  <= nextWrite;
         end
         if (!opWrite && lastCycle) begin
            if (state == LO)
               readData[15:0] <= sramDq;
            else if (state == HI)
               readData[31:16] <= sramDq;
         end
      end
   end

   assign sramDq = dqDrive ? dqOut : 16'bz;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: async SRAM model on the pins plus a word-level reference memory.
// Directed cases from the access rules, then randomized back-to-back/idle-separated traffic.
module tb_sram_controller;
   localparam int N    = 2;
   localparam int BASE = 1024;
   localparam int AW   = 18;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rdEn = 1'b0;
   logic          wrEn = 1'b0;
   logic [31:0]   address = '0;
   logic [31:0]   writeData = '0;
   wire  [31:0]   readData;
   wire           ready;
   wire  [AW-1:0] sramAddr;
   wire  [15:0]   sramDq;
   wire           sramWeN;
   wire           sramOeN;

   logic [15:0]   sramMem [0:(1<<AW)-1];
   logic [31:0]   refMem  [0:(1<<(AW-1))-1];
   logic [31:0]   prevRead;
   int            checks = 0;
   int            passed = 0;

   sram_controller #(.BASE_ADDR(BASE), .SRAM_ADDR_W(AW), .ACCESS_CYCLES(N)) dut (
      .clk(clk), .rst(rst), .rdEn(rdEn), .wrEn(wrEn), .address(address),
      .writeData(writeData), .readData(readData), .ready(ready), .sramAddr(sramAddr),
      .sramDq(sramDq), .sramWeN(sramWeN), .sramOeN(sramOeN)
   );

   always #5 clk = ~clk;

   // Asynchronous SRAM: drives data while OE is low, stores while WE is low.
   assign sramDq = (!sramOeN && sramWeN) ? sramMem[sramAddr] : 16'bz;
   always @(negedge clk) if (!sramWeN) sramMem[sramAddr] <= sramDq;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp) passed++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic int unsigned refIdx(input logic [31:0] a);
      return ((a - BASE) >> 2) % (1 << (AW-1));
   endfunction

   task automatic clearReq();
      @(posedge clk); #1;
      rdEn = 1'b0;
      wrEn = 1'b0;
   endtask

   task automatic doAccess(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input string tag);
      int unsigned idx;
      int          k, errs, freeze;
      logic [31:0] expRead;
      bit          done;
      idx     = refIdx(addr);
      expRead = wr ? prevRead : refMem[idx];
      @(posedge clk); #1;
      rdEn = rd; wrEn = wr; address = addr; writeData = wd;
      k = 0; errs = 0; freeze = -1; done = 0;
      while (!done && k < 64) begin
         @(negedge clk);
         if (k >= 1 && k <= 2*N) begin
            if (sramWeN !== !wr) errs++;
            if (sramOeN !== wr) errs++;
            if (sramAddr !== AW'(idx*2 + ((k > N) ? 1 : 0))) errs++;
         end else if (sramWeN !== 1'b1 || sramOeN !== 1'b1) errs++;
         if (ready === 1'b1) begin
            done   = 1;
            freeze = k;
         end
         k++;
      end
      checkVal({tag, " freeze"}, freeze, 2*N+1);
      checkVal({tag, " pins"}, errs, 0);
      checkVal({tag, " rdata"}, readData, expRead);
      if (wr) begin
         refMem[idx] = wd;
         checkVal({tag, " sram"}, {sramMem[2*idx+1], sramMem[2*idx]}, wd);
      end else begin
         prevRead = expRead;
      end
   endtask

   initial begin
      int unsigned ridx;
      int          op;
      for (int i = 0; i < (1<<AW); i++) sramMem[i] = '0;
      for (int i = 0; i < (1<<(AW-1)); i++) refMem[i] = '0;
      prevRead = '0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkVal("rst ready", ready, 1);
      checkVal("rst rdata", readData, 0);
      checkVal("rst weN", sramWeN, 1);
      checkVal("rst oeN", sramOeN, 1);

      doAccess(0, 1, 1024, 32'hDEADBEEF, "wr1024");
      checkVal("sram0", sramMem[0], 32'h0000BEEF);
      checkVal("sram1", sramMem[1], 32'h0000DEAD);
      doAccess(1, 0, 1024, 0, "rd1024");
      clearReq();
      doAccess(0, 1, 1036, 32'h12345678, "wr1036");
      checkVal("sram6", sramMem[6], 32'h00005678);
      checkVal("sram7", sramMem[7], 32'h00001234);
      doAccess(1, 0, 1037, 0, "rd1037");
      doAccess(1, 1, 1040, 32'hAAAA5555, "rdwr1040");
      doAccess(1, 0, 1040, 0, "rd1040");
      clearReq();
      doAccess(0, 1, 1020, 32'h0BADF00D, "wrWrap");
      checkVal("wrapLo", sramMem[18'h3FFFE], 32'h0000F00D);
      doAccess(1, 0, 1022, 0, "rdWrap");
      clearReq();

      // Reset lands in the second LO cycle of a write.
      @(posedge clk); #1;
      wrEn = 1'b1; address = 1044; writeData = 32'hCAFEF00D;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      wrEn = 1'b0;
      @(negedge clk);
      checkVal("midRst weN", sramWeN, 1);
      checkVal("midRst oeN", sramOeN, 1);
      checkVal("midRst ready", ready, 1);
      checkVal("midRst rdata", readData, 0);
      prevRead = '0;
      doAccess(1, 0, 1028, 0, "rdAfterRst");
      clearReq();

      for (int i = 0; i < 60; i++) begin
         op   = $urandom_range(0, 2);
         ridx = $urandom_range(0, 15);
         if (ridx == 5) ridx = 6;
         doAccess(op != 1, op != 0, BASE + ridx*4 + $urandom_range(0, 3), $urandom, "rand");
         if ($urandom_range(0, 1) == 1) clearReq();
      end
      clearReq();
      @(negedge clk);
      checkVal("end ready", ready, 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
